stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 144 ++++++++++++++
 tb/tb_stack_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter giving two requesters push/pop access to
// one stack with a fixed four-cycle transaction (IDLE, ISSUE, WAIT, RESP).
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   REQx_VALID/POP/DATA      request from requester x (POP=1 pop, 0 push)
//   REQx_READY               combinational accept, IDLE only
//   RSPx_VALID               one-cycle response strobe to requester x
//   RSP_DATA, RSP_ERR        shared response payload
//   STK_PUSH/POP/DIN         strobes and data to the stack
//   STK_DOUT/FULL/EMPTY      registered stack status
//   BUSY                     FSM not in IDLE
//   ERR_CNT                  saturating error count (STACK_ARB_ERR_CNT_EN only)
//
// Optional feature macro: STACK_ARB_ERR_CNT_EN
module stack_arbiter #(
  parameter int unsigned DATA_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic                  REQ1_VALID,
  input  logic                  REQ0_POP,
  input  logic                  REQ1_POP,
  input  logic [DATA_WIDTH-1:0] REQ0_DATA,
  input  logic [DATA_WIDTH-1:0] REQ1_DATA,
  output logic                  REQ0_READY,
  output logic                  REQ1_READY,
  output logic                  RSP0_VALID,
  output logic                  RSP1_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  STK_PUSH,
  output logic                  STK_POP,
  output logic [DATA_WIDTH-1:0] STK_DIN,
  input  logic [DATA_WIDTH-1:0] STK_DOUT,
  input  logic                  STK_FULL,
  input  logic                  STK_EMPTY,
  output logic                  BUSY
`ifdef STACK_ARB_ERR_CNT_EN
  ,
  output logic [7:0]            ERR_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   last_gnt_q;
  logic   gnt_q;
  logic   op_q;
  logic   err_q;
  logic   gnt;
  logic   accept;

  // Next state, round-robin grant and the combinational handshake/strobes.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    STK_PUSH   = 1'b0;
    STK_POP    = 1'b0;
    // Lone requester wins; on a tie the one not granted last wins.
    gnt = (REQ0_VALID && REQ1_VALID) ? ~last_gnt_q : REQ1_VALID;
    case (state_q)
      IDLE: begin
        if (!RST && (REQ0_VALID || REQ1_VALID)) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        // RST gating keeps a reset-aborted request off the stack.
        if (!RST) begin
          if (op_q) STK_POP  = !STK_EMPTY;
          else      STK_PUSH = !STK_FULL;
        end
      end
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    REQ0_READY = accept && !gnt;
    REQ1_READY = accept && gnt;
  end

  // State register, request capture and registered response outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      op_q       <= 1'b0;
      err_q      <= 1'b0;
      STK_DIN    <= '0;
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
      RSP_DATA   <= '0;
      RSP_ERR    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      state_q    <= state_d;
      BUSY       <= (state_d != IDLE);
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
      RSP_ERR    <= 1'b0;
      if (accept) begin
        gnt_q      <= gnt;
        last_gnt_q <= gnt;
        op_q       <= gnt ? REQ1_POP : REQ0_POP;
        // STK_DIN doubles as the captured push-data register.
        STK_DIN    <= gnt ? REQ1_DATA : REQ0_DATA;
      end
      if (state_q == ISSUE) begin
        err_q <= op_q ? STK_EMPTY : STK_FULL;
      end
      if (state_q == WAIT) begin
        RSP0_VALID <= !gnt_q;
        RSP1_VALID <= gnt_q;
        RSP_DATA   <= STK_DOUT;
        RSP_ERR    <= err_q;
      end
    end
  end

`ifdef STACK_ARB_ERR_CNT_EN
  // RSP_ERR is only ever high during RESP, so it marks one error response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_CNT <= 8'd0;
    end else if (RSP_ERR && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed, table-driven bench for stack_arbiter.
module tb_stack_arbiter;

  localparam int unsigned DW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ0_VALID, REQ1_VALID, REQ0_POP, REQ1_POP;
  logic [DW-1:0] REQ0_DATA, REQ1_DATA;
  logic          REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          RSP_ERR, STK_PUSH, STK_POP;
  logic [DW-1:0] STK_DIN;
  logic [DW-1:0] STK_DOUT;
  logic          STK_FULL, STK_EMPTY, BUSY;
`ifdef STACK_ARB_ERR_CNT_EN
  logic [7:0]    ERR_CNT;
`endif

  // Stack inputs come either from the vector or from a small stack model.
  logic          use_model;
  logic [DW-1:0] v_dout;
  logic          v_full, v_empty;
  logic [DW-1:0] m_mem [4];
  logic [2:0]    m_cnt;
  logic [DW-1:0] m_dout;

  assign STK_DOUT  = use_model ? m_dout : v_dout;
  assign STK_FULL  = use_model ? (m_cnt == 3'd4) : v_full;
  assign STK_EMPTY = use_model ? (m_cnt == 3'd0) : v_empty;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) begin
      m_cnt  <= 3'd0;
      m_dout <= '0;
    end else if (STK_PUSH) begin
      m_mem[m_cnt[1:0]] <= STK_DIN;
      m_cnt             <= m_cnt + 3'd1;
      m_dout            <= STK_DIN;
    end else if (STK_POP) begin
      m_dout <= m_mem[2'(m_cnt - 3'd1)];
      m_cnt  <= m_cnt - 3'd1;
    end
  end

  stack_arbiter #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
    .REQ0_POP(REQ0_POP), .REQ1_POP(REQ1_POP),
    .REQ0_DATA(REQ0_DATA), .REQ1_DATA(REQ1_DATA),
    .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
    .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .STK_PUSH(STK_PUSH), .STK_POP(STK_POP), .STK_DIN(STK_DIN),
    .STK_DOUT(STK_DOUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
    .BUSY(BUSY)
`ifdef STACK_ARB_ERR_CNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  typedef struct {
    logic          v0, v1, p0, p1;
    logic [DW-1:0] d0, d1;
    logic          full, empty;
    logic [DW-1:0] dout;
    logic          eg, epush, epop, eerr;
    logic [DW-1:0] erdata;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 20) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // One full transaction, checked at accept, strobe, response and after.
  task automatic do_txn(input vec_t v);
    wait_idle();
    REQ0_VALID = v.v0; REQ1_VALID = v.v1;
    REQ0_POP = v.p0;   REQ1_POP = v.p1;
    REQ0_DATA = v.d0;  REQ1_DATA = v.d1;
    v_full = v.full; v_empty = v.empty; v_dout = v.dout;
    #1;
    chk("ready0", 32'(REQ0_READY), 32'(!v.eg));
    chk("ready1", 32'(REQ1_READY), 32'(v.eg));
    tick();
    // Late changes must not disturb the captured request.
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    REQ0_DATA = ~v.d0; REQ1_DATA = ~v.d1;
    REQ0_POP = ~v.p0;  REQ1_POP = ~v.p1;
    #1;
    chk("stk_push", 32'(STK_PUSH), 32'(v.epush));
    chk("stk_pop", 32'(STK_POP), 32'(v.epop));
    if (v.epush) chk("stk_din", 32'(STK_DIN), 32'(v.eg ? v.d1 : v.d0));
    chk("busy_issue", 32'(BUSY), 32'd1);
    tick();
    chk("no_early_rsp", 32'({RSP0_VALID, RSP1_VALID, STK_PUSH, STK_POP}), 32'd0);
    tick();
    chk("rsp0_valid", 32'(RSP0_VALID), 32'(!v.eg));
    chk("rsp1_valid", 32'(RSP1_VALID), 32'(v.eg));
    chk("rsp_err", 32'(RSP_ERR), 32'(v.eerr));
    chk("rsp_data", 32'(RSP_DATA), 32'(v.erdata));
    v_dout = ~v.dout;
    tick();
    chk("rsp_done", 32'({RSP0_VALID, RSP1_VALID, RSP_ERR, BUSY}), 32'd0);
    chk("rsp_data_hold", 32'(RSP_DATA), 32'(v.erdata));
  endtask

  vec_t tbl [8];
  vec_t tv;
  logic exp_r0;

  initial begin
    //          v0 v1 p0 p1 d0     d1     fl em dout   eg ps pp er rdata
    tbl[0] = '{1, 0, 0, 0, 2'b10, 2'b00, 0, 1, 2'b10, 0, 1, 0, 0, 2'b10};
    tbl[1] = '{0, 1, 0, 1, 2'b00, 2'b11, 0, 1, 2'b01, 1, 0, 0, 1, 2'b01};
    tbl[2] = '{1, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b11, 0, 0, 0, 1, 2'b11};
    tbl[3] = '{1, 1, 0, 1, 2'b11, 2'b00, 0, 0, 2'b11, 1, 0, 1, 0, 2'b11};
    tbl[4] = '{1, 1, 1, 0, 2'b00, 2'b01, 0, 0, 2'b10, 0, 0, 1, 0, 2'b10};
    tbl[5] = '{0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 2'b01, 1, 1, 0, 0, 2'b01};
    tbl[6] = '{1, 1, 0, 0, 2'b00, 2'b10, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00};
    tbl[7] = '{1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 0, 0, 1, 2'b10};

    use_model = 1'b0;
    v_full = 1'b0; v_empty = 1'b1; v_dout = '0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    REQ0_POP = 1'b0;   REQ1_POP = 1'b0;
    REQ0_DATA = 2'b11; REQ1_DATA = 2'b11;
    RST = 1'b1;
    tick();
    tick();
    // Still in reset with both requests pending.
    chk("rst_ready", 32'({REQ0_READY, REQ1_READY}), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_rsp", 32'({RSP0_VALID, RSP1_VALID, RSP_ERR}), 32'd0);
    chk("rst_stk", 32'({STK_PUSH, STK_POP}), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_stk_din", 32'(STK_DIN), 32'd0);
    RST = 1'b0;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    tick();
    chk("idle_busy", 32'(BUSY), 32'd0);

    for (int i = 0; i < 8; i++) do_txn(tbl[i]);
`ifdef STACK_ARB_ERR_CNT_EN
    chk("err_cnt_3", 32'(ERR_CNT), 32'd3);
`endif

    // Both requesters held valid: grants alternate every 4 cycles.
    do_reset();
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    REQ0_POP = 1'b0;   REQ1_POP = 1'b0;
    v_full = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_r0 = (k % 8) == 0;
      chk("rr_ready0", 32'(REQ0_READY), 32'(exp_r0));
      chk("rr_ready1", 32'(REQ1_READY), 32'((k % 8) == 4));
      tick();
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    wait_idle();

    // Reset while in WAIT aborts the request.
    REQ1_VALID = 1'b1; REQ1_POP = 1'b0; REQ1_DATA = 2'b01;
    #1;
    chk("abort_ready1", 32'(REQ1_READY), 32'd1);
    tick();
    REQ1_VALID = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_rsp", 32'({RSP0_VALID, RSP1_VALID, STK_PUSH, STK_POP}), 32'd0);
      tick();
    end
    tv = '{1, 1, 0, 0, 2'b11, 2'b10, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00};
    do_txn(tv);

    // Push then pop through the stack model.
    do_reset();
    use_model = 1'b1;
    tv = '{0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 2'b00, 1, 1, 0, 0, 2'b01};
    do_txn(tv);
    tv = '{0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 1, 0, 2'b01};
    do_txn(tv);
    tv = '{0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0, 1, 2'b01};
    do_txn(tv);
    use_model = 1'b0;

`ifdef STACK_ARB_ERR_CNT_EN
    // 300 push-on-full errors saturate the counter.
    do_reset();
    chk("err_cnt_rst", 32'(ERR_CNT), 32'd0);
    tv = '{1, 0, 0, 0, 2'b10, 2'b00, 1, 0, 2'b00, 0, 0, 0, 1, 2'b00};
    for (int k = 0; k < 300; k++) do_txn(tv);
    chk("err_cnt_sat", 32'(ERR_CNT), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
